// File: rtl/ysyx_25040111_xbar_rd.sv
// AXI-lite read-channel crossbar: LSU read master to CLINT or memory, one read in flight.
// Misaligned addresses get a local DECERR without touching either slave.
module ysyx_25040111_xbar_rd #(
  parameter logic [31:0] CLINT_BASE = 32'ha0000048,
  parameter logic [31:0] CLINT_MASK = 32'hfffffff8
) (
  input  logic        clk,
  input  logic        rst_n,
  // master side
  input  logic [31:0] m_araddr,
  input  logic        m_arvalid,
  output logic        m_arready,
  output logic [31:0] m_rdata,
  output logic [1:0]  m_rresp,
  output logic        m_rvalid,
  input  logic        m_rready,
  // CLINT slave
  output logic [31:0] clint_araddr,
  output logic        clint_arvalid,
  input  logic        clint_arready,
  input  logic [31:0] clint_rdata,
  input  logic [1:0]  clint_rresp,
  input  logic        clint_rvalid,
  output logic        clint_rready,
  // memory slave
  output logic [31:0] mem_araddr,
  output logic        mem_arvalid,
  input  logic        mem_arready,
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  mem_rresp,
  input  logic        mem_rvalid,
  output logic        mem_rready
);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StErr} state_e;

  localparam logic SelMem   = 1'b0;
  localparam logic SelClint = 1'b1;

  state_e      r_state;
  state_e      w_state_next;
  logic [31:0] r_addr;
  logic [31:0] w_addr_next;
  logic        r_sel;
  logic        w_sel_next;

  logic        w_misaligned;
  logic        w_is_clint;
  logic        w_sel_arready;
  logic        w_sel_rvalid;
  logic [31:0] w_sel_rdata;
  logic [1:0]  w_sel_rresp;

  assign w_misaligned  = |m_araddr[1:0];
  assign w_is_clint    = (m_araddr & CLINT_MASK) == CLINT_BASE;
  assign w_sel_arready = (r_sel == SelClint) ? clint_arready : mem_arready;
  assign w_sel_rvalid  = (r_sel == SelClint) ? clint_rvalid  : mem_rvalid;
  assign w_sel_rdata   = (r_sel == SelClint) ? clint_rdata   : mem_rdata;
  assign w_sel_rresp   = (r_sel == SelClint) ? clint_rresp   : mem_rresp;

  // The CLINT samples araddr after its AR handshake, so the address comes
  // straight from the latch and only changes when a new AR is accepted.
  assign clint_araddr = r_addr;
  assign mem_araddr   = r_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_addr  <= 32'h0;
      r_sel   <= SelMem;
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
      r_sel   <= w_sel_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_sel_next   = r_sel;
    unique case (r_state)
      StIdle: begin
        if (m_arvalid) begin
          w_addr_next = m_araddr;
          if (w_misaligned) begin
            w_state_next = StErr;
          end else begin
            w_sel_next   = w_is_clint ? SelClint : SelMem;
            w_state_next = StAddr;
          end
        end
      end
      StAddr: begin
        if (w_sel_arready) w_state_next = StData;
      end
      StData: begin
        if (w_sel_rvalid && m_rready) w_state_next = StIdle;
      end
      StErr: begin
        if (m_rready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    m_arready     = (r_state == StIdle);
    m_rvalid      = 1'b0;
    m_rdata       = 32'h0;
    m_rresp       = 2'b00;
    clint_arvalid = 1'b0;
    clint_rready  = 1'b0;
    mem_arvalid   = 1'b0;
    mem_rready    = 1'b0;
    unique case (r_state)
      StAddr: begin
        clint_arvalid = (r_sel == SelClint);
        mem_arvalid   = (r_sel == SelMem);
      end
      StData: begin
        m_rvalid     = w_sel_rvalid;
        m_rdata      = w_sel_rdata;
        m_rresp      = w_sel_rresp;
        clint_rready = (r_sel == SelClint) && m_rready;
        mem_rready   = (r_sel == SelMem) && m_rready;
      end
      StErr: begin
        m_rvalid = 1'b1;
        m_rresp  = 2'b11;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_25040111_xbar_rd.sv
// Bench for the read crossbar: CLINT and memory slave models, scoreboard on the R channel.
module tb_ysyx_25040111_xbar_rd;

  localparam logic [31:0] MTIME_LO = 32'h89ab_cdef;
  localparam logic [31:0] MTIME_HI = 32'h0000_0001;

  logic        clk;
  logic        rst_n;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready;
  logic [31:0] clint_araddr;
  logic        clint_arvalid;
  logic        clint_arready;
  logic [31:0] clint_rdata;
  logic [1:0]  clint_rresp;
  logic        clint_rvalid;
  logic        clint_rready;
  logic [31:0] mem_araddr;
  logic        mem_arvalid;
  logic        mem_arready;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;
  logic        mem_rvalid;
  logic        mem_rready;

  int n_checks = 0;
  int n_fail   = 0;
  int n_resp   = 0;
  int n_clint_ar = 0;
  int n_mem_ar   = 0;

  logic [33:0] exp_q[$];

  // slave model configuration
  int          clint_cycles = 1;
  int          mem_cycles   = 3;
  logic [31:0] mem_data_cfg = 32'h0;
  logic [1:0]  mem_resp_cfg = 2'b00;

  int          c_cnt;
  int          m_cnt;
  logic        c_pend;
  logic [31:0] c_addr;
  logic [31:0] m_addr;

  ysyx_25040111_xbar_rd dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .m_araddr      (m_araddr),
    .m_arvalid     (m_arvalid),
    .m_arready     (m_arready),
    .m_rdata       (m_rdata),
    .m_rresp       (m_rresp),
    .m_rvalid      (m_rvalid),
    .m_rready      (m_rready),
    .clint_araddr  (clint_araddr),
    .clint_arvalid (clint_arvalid),
    .clint_arready (clint_arready),
    .clint_rdata   (clint_rdata),
    .clint_rresp   (clint_rresp),
    .clint_rvalid  (clint_rvalid),
    .clint_rready  (clint_rready),
    .mem_araddr    (mem_araddr),
    .mem_arvalid   (mem_arvalid),
    .mem_arready   (mem_arready),
    .mem_rdata     (mem_rdata),
    .mem_rresp     (mem_rresp),
    .mem_rvalid    (mem_rvalid),
    .mem_rready    (mem_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // CLINT: arready after clint_cycles of arvalid; reads araddr the cycle after the handshake.
  assign clint_arready = clint_arvalid && (c_cnt + 1 >= clint_cycles);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_cnt        <= 0;
      c_pend       <= 1'b0;
      c_addr       <= 32'h0;
      clint_rvalid <= 1'b0;
      clint_rdata  <= 32'h0;
      clint_rresp  <= 2'b00;
    end else begin
      if (clint_arvalid && clint_arready) begin
        c_cnt  <= 0;
        c_pend <= 1'b1;
        c_addr <= clint_araddr;
      end else if (clint_arvalid) begin
        c_cnt <= c_cnt + 1;
      end
      if (c_pend) begin
        c_pend       <= 1'b0;
        clint_rvalid <= 1'b1;
        clint_rdata  <= clint_araddr[2] ? MTIME_HI : MTIME_LO;
        clint_rresp  <= 2'b00;
      end
      if (clint_rvalid && clint_rready) clint_rvalid <= 1'b0;
    end
  end

  assign mem_arready = mem_arvalid && (m_cnt + 1 >= mem_cycles);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt      <= 0;
      m_addr     <= 32'h0;
      mem_rvalid <= 1'b0;
      mem_rdata  <= 32'h0;
      mem_rresp  <= 2'b00;
    end else begin
      if (mem_arvalid && mem_arready) begin
        m_cnt      <= 0;
        m_addr     <= mem_araddr;
        mem_rvalid <= 1'b1;
        mem_rdata  <= mem_data_cfg;
        mem_rresp  <= mem_resp_cfg;
      end else if (mem_arvalid) begin
        m_cnt <= m_cnt + 1;
      end
      if (mem_rvalid && mem_rready) mem_rvalid <= 1'b0;
    end
  end

  // AR activity counters, address-hold checks and R-channel scoreboard
  always @(negedge clk) begin : mon
    logic [33:0] e;
    if (clint_arvalid) n_clint_ar++;
    if (mem_arvalid) n_mem_ar++;
    if (rst_n && (clint_rvalid || c_pend)) check_eq("clint_araddr_hold", clint_araddr, c_addr);
    if (rst_n && mem_rvalid) check_eq("mem_araddr_hold", mem_araddr, m_addr);
    if (rst_n && m_rvalid && m_rready) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_resp", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("rdata", m_rdata, e[31:0]);
        check_eq("rresp", m_rresp, e[33:32]);
        n_resp++;
      end
    end
  end

  task automatic rd(input logic [31:0] addr, input logic [31:0] ed, input logic [1:0] er,
                    input int stall);
    int cnt;
    exp_q.push_back({er, ed});
    @(posedge clk);
    #1;
    m_araddr  = addr;
    m_arvalid = 1'b1;
    m_rready  = (stall == 0);
    cnt = 0;
    @(negedge clk);
    while (!m_arready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("ar_accept", m_arready, 1);
    @(posedge clk);
    #1;
    // a misaligned AR left asserted outside IDLE must be ignored
    m_araddr = 32'h0000_0003;
    cnt = 0;
    @(negedge clk);
    while (!m_rvalid && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("r_seen", m_rvalid, 1);
    for (int i = 0; i < stall; i++) begin
      check_eq("stall_rvalid", m_rvalid, 1);
      check_eq("stall_rdata", m_rdata, ed);
      check_eq("stall_rresp", m_rresp, er);
      check_eq("stall_slave_rready", {clint_rready, mem_rready}, 0);
      check_eq("stall_arready", m_arready, 0);
      @(posedge clk);
      #1;
      if (i == stall - 1) m_rready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    m_araddr  = 32'h0;
    @(negedge clk);
    check_eq("idle_arready", m_arready, 1);
    check_eq("idle_rvalid", m_rvalid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int m0;
    rst_n     = 1'b0;
    m_araddr  = 32'h0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    #2;
    check_eq("rst_arready", m_arready, 1);
    check_eq("rst_rvalid", m_rvalid, 0);
    check_eq("rst_rdata", m_rdata, 0);
    check_eq("rst_rresp", m_rresp, 0);
    check_eq("rst_arvalid", {clint_arvalid, mem_arvalid}, 0);
    check_eq("rst_rready", {clint_rready, mem_rready}, 0);
    check_eq("rst_araddr", {clint_araddr, mem_araddr}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // CLINT mtime low then high: each read pays its own AR cycle
    c0 = n_clint_ar; m0 = n_mem_ar;
    rd(32'ha000_0048, MTIME_LO, 2'b00, 0);
    check_eq("clint_lo_ar_cycles", n_clint_ar - c0, 1);
    check_eq("clint_lo_mem_ar", n_mem_ar - m0, 0);
    c0 = n_clint_ar; m0 = n_mem_ar;
    rd(32'ha000_004c, MTIME_HI, 2'b00, 2);
    check_eq("clint_hi_ar_cycles", n_clint_ar - c0, 1);
    check_eq("clint_hi_mem_ar", n_mem_ar - m0, 0);

    // memory with slow arready and a passed-through SLVERR
    mem_cycles = 3; mem_data_cfg = 32'hdead_beef; mem_resp_cfg = 2'b10;
    c0 = n_clint_ar; m0 = n_mem_ar;
    rd(32'h8000_0000, 32'hdead_beef, 2'b10, 0);
    check_eq("mem_ar_cycles", n_mem_ar - m0, 3);
    check_eq("mem_clint_ar", n_clint_ar - c0, 0);

    // misaligned: local DECERR held 4 cycles, no slave touched
    c0 = n_clint_ar; m0 = n_mem_ar;
    rd(32'h8000_0002, 32'h0, 2'b11, 4);
    check_eq("err_no_slave_ar", (n_clint_ar - c0) + (n_mem_ar - m0), 0);

    // master backpressure in DATA
    mem_cycles = 1; mem_data_cfg = 32'h1234_5678; mem_resp_cfg = 2'b00;
    rd(32'h8000_1000, 32'h1234_5678, 2'b00, 5);

    // just outside the CLINT decode window, both sides
    c0 = n_clint_ar;
    mem_data_cfg = 32'h0bad_f00d;
    rd(32'ha000_0050, 32'h0bad_f00d, 2'b00, 0);
    mem_data_cfg = 32'h0c0f_fee0;
    rd(32'ha000_0044, 32'h0c0f_fee0, 2'b00, 0);
    check_eq("near_clint_to_mem", n_clint_ar - c0, 0);

    // asynchronous reset while waiting in ADDR
    mem_cycles = 10;
    @(posedge clk);
    #1;
    m_araddr  = 32'h8000_0010;
    m_arvalid = 1'b1;
    @(posedge clk);
    #1;
    m_arvalid = 1'b0;
    @(negedge clk);
    check_eq("addr_phase_mem_arvalid", mem_arvalid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_arvalid", {clint_arvalid, mem_arvalid}, 0);
    check_eq("rst_mid_rvalid", m_rvalid, 0);
    check_eq("rst_mid_arready", m_arready, 1);
    check_eq("rst_mid_araddr", mem_araddr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_cycles = 2; mem_data_cfg = 32'h5555_aaaa; mem_resp_cfg = 2'b01;
    rd(32'h8000_0010, 32'h5555_aaaa, 2'b01, 0);
    rd(32'ha000_0048, MTIME_LO, 2'b00, 1);

    check_eq("sb_drained", exp_q.size(), 0);
    check_eq("resp_count", n_resp, 9);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
